// File: rtl/stack_pkg.sv
// Shared definitions for the stack command sequencer: default sizes,
// opcode values, FSM state encoding and the per-opcode occupancy needs.
package stack_pkg;

  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 8;
  localparam int CW_DEF    = 4;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSHI = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_TOS   = 3'd3;
  localparam logic [2:0] OP_ADD   = 3'd4;
  localparam logic [2:0] OP_SUB   = 3'd5;
  localparam logic [2:0] OP_AND   = 3'd6;
  localparam logic [2:0] OP_NOT   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PUSH = 3'd1,
    S_POP1 = 3'd2,
    S_PEEK = 3'd3,
    S_CAP1 = 3'd4,
    S_CAP2 = 3'd5,
    S_WB   = 3'd6
  } state_t;

  // Minimum number of stacked operands an opcode consumes.
  function automatic logic [1:0] op_min_depth(input logic [2:0] op);
    logic [1:0] need;
    case (op)
      OP_POP, OP_TOS, OP_NOT:  need = 2'd1;
      OP_ADD, OP_SUB, OP_AND:  need = 2'd2;
      default:                 need = 2'd0;
    endcase
    return need;
  endfunction

endpackage

// File: rtl/stack_alu8.sv
// Combinational ALU for the stack sequencer. B is the deeper operand;
// results wrap modulo 2^DW.
module stack_alu8
  import stack_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          zero
);

  // Operation select and zero flag.
  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = b + a;
      OP_SUB:  result = b - a;
      OP_AND:  result = b & a;
      OP_NOT:  result = ~a;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/stack_cmd_sequencer.sv
// Command front-end for the operand stack: one command per handshake,
// sequenced into push/pop/tos strobes with occupancy tracking.
module stack_cmd_sequencer
  import stack_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [DW-1:0] cmd_imm,
  output logic          res_valid,
  output logic [DW-1:0] res_data,
  output logic          zero,
  output logic          err,
  output logic [CW-1:0] depth,
  output logic          stk_push,
  output logic          stk_pop,
  output logic          stk_tos,
  output logic [DW-1:0] stk_din,
  input  logic [DW-1:0] stk_dout
);

  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d;
  logic [CW-1:0] depth_q, depth_d;
  logic          push_q, push_d, pop_q, pop_d, tos_q, tos_d;
  logic [DW-1:0] din_q, din_d;
  logic          rv_q, rv_d, err_q, err_d, zero_q, zero_d;
  logic [DW-1:0] hold_q, hold_d;

  logic          room_ok, operand_ok, accept_ok, is_binary;
  logic [DW-1:0] alu_a, alu_res;
  logic          alu_zero;

  assign room_ok    = (depth_q < FULL_C);
  assign operand_ok = (depth_q >= CW'(op_min_depth(cmd_op)));
  assign accept_ok  = (cmd_op == OP_PUSHI) ? room_ok : operand_ok;
  assign is_binary  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND);

  // CAP2 combines the held top operand with the second one arriving now.
  assign alu_a = (state_q == S_CAP2) ? a_q : stk_dout;

  stack_alu8 #(.DW(DW)) u_alu (
    .op     (op_q),
    .a      (alu_a),
    .b      (stk_dout),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Next-state, strobe and occupancy computation.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    depth_d = depth_q;
    push_d  = 1'b0;
    pop_d   = 1'b0;
    tos_d   = 1'b0;
    din_d   = din_q;
    rv_d    = 1'b0;
    hold_d  = hold_q;
    err_d   = 1'b0;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          if (!accept_ok) begin
            err_d = 1'b1;
          end else begin
            case (cmd_op)
              OP_NOP: state_d = S_IDLE;
              OP_PUSHI: begin
                push_d  = 1'b1;
                din_d   = cmd_imm;
                depth_d = depth_q + ONE_C;
                state_d = S_PUSH;
              end
              OP_TOS: begin
                tos_d   = 1'b1;
                state_d = S_PEEK;
              end
              default: begin
                pop_d   = 1'b1;
                depth_d = depth_q - ONE_C;
                state_d = S_POP1;
              end
            endcase
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PUSH: state_d = S_IDLE;
      S_POP1: begin
        state_d = S_CAP1;
        if (op_q == OP_POP) begin
          rv_d = 1'b1;
        end else if (is_binary) begin
          pop_d   = 1'b1;
          depth_d = depth_q - ONE_C;
        end else begin
          rv_d = 1'b0;
        end
      end
      S_PEEK: begin
        rv_d    = 1'b1;
        state_d = S_CAP1;
      end
      S_CAP1: begin
        a_d = stk_dout;
        if ((op_q == OP_POP) || (op_q == OP_TOS)) begin
          hold_d  = stk_dout;
          state_d = S_IDLE;
        end else if (op_q == OP_NOT) begin
          push_d  = 1'b1;
          din_d   = alu_res;
          zero_d  = alu_zero;
          depth_d = depth_q + ONE_C;
          state_d = S_WB;
        end else begin
          state_d = S_CAP2;
        end
      end
      S_CAP2: begin
        push_d  = 1'b1;
        din_d   = alu_res;
        zero_d  = alu_zero;
        depth_d = depth_q + ONE_C;
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops every strobe immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= '0;
      depth_q <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      tos_q   <= 1'b0;
      din_q   <= '0;
      rv_q    <= 1'b0;
      hold_q  <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      depth_q <= depth_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      tos_q   <= tos_d;
      din_q   <= din_d;
      rv_q    <= rv_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = rv_q;
  // The stack's registered read data is valid during the CAP1 pulse.
  assign res_data  = rv_q ? stk_dout : hold_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign depth     = depth_q;
  assign stk_push  = push_q;
  assign stk_pop   = pop_q;
  assign stk_tos   = tos_q;
  assign stk_din   = din_q;

endmodule

// File: tb/tb_stack_cmd_sequencer.sv
// Bench for stack_cmd_sequencer: directed vector table, randomized commands
// against a queue-based stack model, and a reset-mid-command sequence.
module tb_stack_cmd_sequencer;

  localparam logic [2:0] NOP = 3'd0, PUSHI = 3'd1, POP = 3'd2, TOS = 3'd3;
  localparam logic [2:0] ADD = 3'd4, SUB = 3'd5, AND = 3'd6, NOT = 3'd7;

  typedef struct {
    logic [2:0] op;
    logic [7:0] imm;
    logic       err;
    logic       rv;
    logic [7:0] res;
    logic [3:0] dep;
    logic       zero;
    int         lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_imm = 8'd0;
  logic       res_valid;
  logic [7:0] res_data;
  logic       zero, err;
  logic [3:0] depth;
  logic       stk_push, stk_pop, stk_tos;
  logic [7:0] stk_din;
  logic [7:0] stk_dout;

  int checks = 0;
  int errors = 0;

  stack_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm), .res_valid(res_valid),
    .res_data(res_data), .zero(zero), .err(err), .depth(depth),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos),
    .stk_din(stk_din), .stk_dout(stk_dout)
  );

  always #5 clk = ~clk;

  // Behavioural stack with registered read data.
  logic [7:0] smem [0:7];
  int         sp;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp       <= 0;
      stk_dout <= 8'd0;
    end else if (stk_push && sp < 8) begin
      smem[sp] <= stk_din;
      sp       <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= smem[sp-1];
      sp       <= sp - 1;
    end else if (stk_tos && sp > 0) begin
      stk_dout <= smem[sp-1];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Continuous monitor: one strobe at most, depth moves with its strobe.
  int  prev_dep;
  bit  prev_ok = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (int'(stk_push) + int'(stk_pop) + int'(stk_tos) > 1) begin
        errors++;
        $display("FAIL strobe_onehot push=%0b pop=%0b tos=%0b", stk_push, stk_pop, stk_tos);
      end
      if (prev_ok && int'(depth) != prev_dep + int'(stk_push) - int'(stk_pop)) begin
        errors++;
        $display("FAIL depth_step got=%0d exp=%0d", depth, prev_dep + int'(stk_push) - int'(stk_pop));
      end
      if (depth > 4'd8) begin
        errors++;
        $display("FAIL depth_max got=%0d exp<=8", depth);
      end
      prev_dep = int'(depth);
      prev_ok  = 1'b1;
    end else begin
      prev_ok = 1'b0;
    end
  end

  // Issue one command and observe it until cmd_ready returns.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] imm,
                         output logic [31:0] err_m, output logic [31:0] rv_m,
                         output logic [7:0] res, output logic [3:0] dep,
                         output logic zq, output int lat, output int nstrb);
    err_m = 32'd0; rv_m = 32'd0; res = 8'd0; lat = 0; nstrb = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    @(negedge clk);
    lat = 1;
    while (1) begin
      if (err) err_m[lat] = 1'b1;
      if (res_valid) begin
        rv_m[lat] = 1'b1;
        res = res_data;
      end
      nstrb += int'(stk_push) + int'(stk_pop) + int'(stk_tos);
      if (cmd_ready || lat >= 20) begin
        cmd_valid = 1'b0;
        break;
      end
      // Busy: scribble on the inputs, they must be ignored.
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 3'($urandom);
      cmd_imm   = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    dep = depth;
    zq  = zero;
  endtask

  function automatic int strobes_for(input logic [2:0] op, input logic e);
    if (e) return 0;
    case (op)
      NOP:           return 0;
      NOT:           return 2;
      ADD, SUB, AND: return 3;
      default:       return 1;
    endcase
  endfunction

  task automatic apply(input vec_t v, input string tag);
    logic [31:0] em, rm;
    logic [7:0]  res;
    logic [3:0]  dep;
    logic        zq;
    int          lat, ns;
    run_cmd(v.op, v.imm, em, rm, res, dep, zq, lat, ns);
    chk({tag, ".err"},  em, v.err ? 32'h2 : 32'h0);
    chk({tag, ".rv"},   rm, v.rv ? 32'h4 : 32'h0);
    if (v.rv) chk({tag, ".res"}, {24'd0, res}, {24'd0, v.res});
    chk({tag, ".dep"},  {28'd0, dep}, {28'd0, v.dep});
    chk({tag, ".zero"}, {31'd0, zq}, {31'd0, v.zero});
    chk({tag, ".lat"},  lat, v.lat);
    chk({tag, ".strb"}, ns, strobes_for(v.op, v.err));
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] imm, input logic e,
                              input logic rv, input logic [7:0] res, input logic [3:0] dep,
                              input logic z, input int lat);
    vec_t v;
    v.op = op; v.imm = imm; v.err = e; v.rv = rv; v.res = res;
    v.dep = dep; v.zero = z; v.lat = lat;
    return v;
  endfunction

  // Reference model: an ordinary queue standing in for the stack.
  logic [7:0] rq[$];
  logic       rzero;

  task automatic model(input logic [2:0] op, input logic [7:0] imm, output vec_t v);
    int         n;
    logic [7:0] a, b, r;
    n = rq.size();
    v = mk(op, imm, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0, 1);
    case (op)
      PUSHI: if (n < 8) begin rq.push_back(imm); v.lat = 2; end else v.err = 1'b1;
      POP:   if (n >= 1) begin v.res = rq.pop_back(); v.rv = 1'b1; v.lat = 3; end else v.err = 1'b1;
      TOS:   if (n >= 1) begin v.res = rq[n-1]; v.rv = 1'b1; v.lat = 3; end else v.err = 1'b1;
      NOT: begin
        if (n >= 1) begin
          a = rq.pop_back(); r = ~a; rq.push_back(r);
          rzero = (r == 8'd0); v.lat = 4;
        end else v.err = 1'b1;
      end
      ADD, SUB, AND: begin
        if (n >= 2) begin
          a = rq.pop_back(); b = rq.pop_back();
          r = (op == ADD) ? 8'(b + a) : (op == SUB) ? 8'(b - a) : (b & a);
          rq.push_back(r); rzero = (r == 8'd0); v.lat = 5;
        end else v.err = 1'b1;
      end
      default: ;
    endcase
    v.dep  = 4'(rq.size());
    v.zero = rzero;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rq.delete();
    rzero = 1'b0;
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    // Directed table from the worked examples.
    tbl.push_back(mk(PUSHI, 8'd5,   0, 0, 8'd0,   4'd1, 0, 2));
    tbl.push_back(mk(PUSHI, 8'd3,   0, 0, 8'd0,   4'd2, 0, 2));
    tbl.push_back(mk(SUB,   8'd0,   0, 0, 8'd0,   4'd1, 0, 5));
    tbl.push_back(mk(POP,   8'd0,   0, 1, 8'd2,   4'd0, 0, 3));
    tbl.push_back(mk(PUSHI, 8'd200, 0, 0, 8'd0,   4'd1, 0, 2));
    tbl.push_back(mk(PUSHI, 8'd100, 0, 0, 8'd0,   4'd2, 0, 2));
    tbl.push_back(mk(ADD,   8'd0,   0, 0, 8'd0,   4'd1, 0, 5));
    tbl.push_back(mk(POP,   8'd0,   0, 1, 8'd44,  4'd0, 0, 3));
    tbl.push_back(mk(PUSHI, 8'h0F,  0, 0, 8'd0,   4'd1, 0, 2));
    tbl.push_back(mk(NOT,   8'd0,   0, 0, 8'd0,   4'd1, 0, 4));
    tbl.push_back(mk(TOS,   8'd0,   0, 1, 8'hF0,  4'd1, 0, 3));
    tbl.push_back(mk(POP,   8'd0,   0, 1, 8'hF0,  4'd0, 0, 3));
    tbl.push_back(mk(POP,   8'd0,   1, 0, 8'd0,   4'd0, 0, 1));
    tbl.push_back(mk(PUSHI, 8'd7,   0, 0, 8'd0,   4'd1, 0, 2));
    tbl.push_back(mk(ADD,   8'd0,   1, 0, 8'd0,   4'd1, 0, 1));
    tbl.push_back(mk(POP,   8'd0,   0, 1, 8'd7,   4'd0, 0, 3));
    tbl.push_back(mk(PUSHI, 8'hFF,  0, 0, 8'd0,   4'd1, 0, 2));
    tbl.push_back(mk(NOT,   8'd0,   0, 0, 8'd0,   4'd1, 1, 4));
    tbl.push_back(mk(NOP,   8'd0,   0, 0, 8'd0,   4'd1, 1, 1));
    tbl.push_back(mk(POP,   8'd0,   0, 1, 8'd0,   4'd0, 1, 3));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(PUSHI, 8'(10 + i), 0, 0, 8'd0, 4'(i + 1), 1, 2));
    tbl.push_back(mk(PUSHI, 8'd99,  1, 0, 8'd0,   4'd8, 1, 1));
    tbl.push_back(mk(AND,   8'd0,   0, 0, 8'd0,   4'd7, 0, 5));
    tbl.push_back(mk(TOS,   8'd0,   0, 1, 8'h10,  4'd7, 0, 3));

    do_reset();
    @(negedge clk);
    chk("rst.ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst.depth", {28'd0, depth}, 32'd0);
    chk("rst.strb",  {29'd0, stk_push, stk_pop, stk_tos}, 32'd0);
    chk("rst.rv_err_zero", {29'd0, res_valid, err, zero}, 32'd0);
    chk("rst.res_data", {24'd0, res_data}, 32'd0);

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("vec%0d", i));

    // Randomized commands against the queue model.
    do_reset();
    for (int i = 0; i < 250; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (rq.size() < 2 && $urandom_range(0, 1) == 1) op = PUSHI;
      model(op, 8'($urandom), v);
      apply(v, $sformatf("rnd%0d", i));
    end

    // Reset while an ADD sits in CAP1.
    do_reset();
    model(PUSHI, 8'd1, v); apply(v, "mid.p1");
    model(PUSHI, 8'd2, v); apply(v, "mid.p2");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_imm = 8'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid.pop1", {31'd0, stk_pop}, 32'd1);
    @(negedge clk);
    chk("mid.cap1_pop", {31'd0, stk_pop}, 32'd1);
    chk("mid.cap1_dep", {28'd0, depth}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("mid.rst_strb", {29'd0, stk_push, stk_pop, stk_tos}, 32'd0);
    chk("mid.rst_dep",  {28'd0, depth}, 32'd0);
    chk("mid.rst_err_rv", {30'd0, err, res_valid}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid.hold_strb", {29'd0, stk_push, stk_pop, stk_tos}, 32'd0);
    end
    rst = 1'b1;
    rq.delete();
    rzero = 1'b0;
    @(negedge clk);
    chk("mid.rel_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mid.rel_dep",   {28'd0, depth}, 32'd0);
    chk("mid.rel_strb",  {29'd0, stk_push, stk_pop, stk_tos}, 32'd0);
    model(PUSHI, 8'd9, v); apply(v, "mid.p9");
    model(POP,   8'd0, v); apply(v, "mid.pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_cmd_sequencer.md
Name: stack_cmd_sequencer

Overview:
- Command front-end that drives the 8-bit operand stack: accepts one stack-machine command per valid/ready handshake and sequences the stack's push/pop/tos strobes.
- Captures the stack's registered data_out and executes ALU ops (pop operands, compute, push result).
- Sits directly upstream of the stack; also returns popped/peeked values to the datapath.

Parameters:
- DW, 8, data width (matches stack data_in/data_out)
- DEPTH, 8, stack capacity used for occupancy checks
- CW, 4, occupancy counter width, must hold 0..DEPTH

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  3  opcode: 0 NOP, 1 PUSHI, 2 POP, 3 TOS, 4 ADD, 5 SUB, 6 AND, 7 NOT
- cmd_imm  in  DW  immediate for PUSHI
- res_valid  out  1  one-cycle pulse, res_data valid (POP/TOS)
- res_data  out  DW  popped/peeked value
- zero  out  1  last ALU result == 0, held until next ALU op
- err  out  1  one-cycle pulse, command rejected (under/overflow)
- depth  out  CW  current stack occupancy
- stk_push, stk_pop, stk_tos  out  1  stack strobes, at most one high per cycle
- stk_din  out  DW  stack write data
- stk_dout  in  DW  stack read data, valid the cycle after a pop/tos strobe

Behaviour:
- Reset: state=IDLE, depth=0, all strobes 0, res_valid=0, err=0, zero=0, res_data=0, operand regs=0. Reset mid-operation abandons the command; no strobe is issued after reset asserts. The stack is reset by the same event (inverted at top level).
- Handshake: accept when cmd_valid & cmd_ready (cycle T). op/imm latched at T; inputs ignored while busy.
- Occupancy check at accept:
  - PUSHI needs depth<DEPTH.
  - POP/TOS/NOT need depth>=1.
  - ADD/SUB/AND need depth>=2.
  - On failure: err=1 at T+1, no strobes, depth unchanged, ready again at T+1.
- NOP: accepted, no effect, ready at T+1.
- States: IDLE, PUSH, POP1, PEEK, CAP1, CAP2, WB.
- PUSHI: T+1 PUSH (stk_push=1, stk_din=imm, depth+1); ready at T+2.
- POP: T+1 POP1 (stk_pop=1, depth-1); T+2 CAP1 (res_valid=1, res_data=stk_dout); ready at T+3.
- TOS: T+1 PEEK (stk_tos=1); T+2 CAP1 (res_valid=1); depth unchanged; ready at T+3.
- NOT: T+1 POP1; T+2 CAP1 (A=stk_dout); T+3 WB (stk_push, stk_din=~A); depth net 0; ready at T+4.
- Binary ops:
  - T+1 POP1.
  - T+2 CAP1: A=stk_dout (top), stk_pop=1.
  - T+3 CAP2: B=stk_dout.
  - T+4 WB: push result.
  - Net depth -1; ready at T+5.
- Arithmetic: ADD=B+A, SUB=B-A (B is the deeper operand), AND=B&A. Results truncated to DW (mod 256), no carry output. zero updated in WB.
- depth changes exactly in the cycle its strobe is asserted; never exceeds DEPTH, never below 0.

Decomposition:
- Shared package stack_pkg: opcode localparams, state encoding, DW/DEPTH defaults.
- One sub-module: stack_alu8, combinational (op, A, B) -> result, zero. FSM and occupancy counter stay in the top module.

Test Plan:
- PUSHI 5, PUSHI 3, SUB, POP -> res_data=2 (0x02), zero=0, depth 2->1->0; SUB ready 5 cycles after accept.
- PUSHI 200, PUSHI 100, ADD, POP -> res_data=44 (wrap).
- PUSHI 0x0F, NOT, TOS -> res_data=0xF0, depth stays 1.
- POP on empty -> err pulse at T+1, no strobes, depth=0. ADD with depth=1 -> err, depth stays 1.
- 8x PUSHI, then 9th PUSHI -> err, depth=8, no stk_push.
- Assert rst=0 during CAP1 of ADD -> strobes drop immediately, depth=0, cmd_ready=1 after release.
- Every test: a bench checker flags any cycle with more than one strobe high.
